ddr5_cmd_scheduler: RTL and testbench
=====================================

Name: ddr5_cmd_scheduler

Overview:
Sits between the trace request source and the DRAM command bus of the DDR5 controller model. Accepts parsed CPU requests (core, operation, address) into a 16-entry in-order queue. Decodes each request into bank group, bank, row and column. Sequences ACT/RD/WR/PRE commands under DDR5 timing constraints, using a closed-page policy by default.

Parameters:
MEM_ADDR_WIDTH, 64, request address width; bits [33:0] are decoded, upper bits are ignored.
CPU_CORE_WIDTH, 4, core ID width.
MEM_OPN_WIDTH, 3, operation code width; 0 = data read, 1 = data write, 2 = instruction fetch.
QUEUE_DEPTH, 16, request queue entries; must be a power of 2.
T_RCD, 39, minimum cycles from ACT to RD/WR.
T_RAS, 76, minimum cycles from ACT to PRE.
T_RTP, 18, minimum cycles from RD to PRE.
T_WRP, 94, minimum cycles from WR to PRE (CWL + BL/2 + tWR).
T_RP, 39, minimum cycles from PRE to the next ACT.
T_CCD, 8, minimum cycles between CAS commands (open-page only).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  queue can accept; equals !full
req_core  in  CPU_CORE_WIDTH  requesting core
req_opn  in  MEM_OPN_WIDTH  operation code
req_addr  in  MEM_ADDR_WIDTH  byte address
req_err  out  1  one-cycle pulse: request with illegal opcode was dropped
q_count  out  $clog2(QUEUE_DEPTH)+1  current queue occupancy
cmd_valid  out  1  command issued this cycle
cmd_type  out  3  0 = NOP, 1 = ACT, 2 = RD, 3 = WR, 4 = PRE
cmd_bg  out  3  bank group = addr[9:7]
cmd_bank  out  2  bank = addr[11:10]
cmd_row  out  16  row = addr[33:18]
cmd_col  out  10  column = {addr[17:12], addr[5:2]}
cmd_core  out  CPU_CORE_WIDTH  core of the request being serviced

Behaviour:
- Reset values: req_ready=1, req_err=0, q_count=0, cmd_valid=0, cmd_type=0, all cmd_* fields=0.
- Reset asserted mid-operation flushes the queue, returns the FSM to IDLE and clears all timers; no PRE is issued.
- Handshake: a request transfers on a rising edge with req_valid && req_ready.
  - Opcode 0, 1 or 2: the request is pushed.
  - Opcode > 2: the handshake completes but nothing is pushed; req_err=1 for the next cycle.
- Queue is a FIFO with wrapping read/write pointers and occupancy count.
  - Full: req_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: q_count is unchanged.
  - Pop when empty: impossible by construction.
- Command outputs:
  - cmd_valid is high for exactly one cycle per command; cmd_type=0 otherwise.
  - cmd_* fields are registered and hold the last serviced request between commands.
  - Opcodes 0 and 2 map to RD; opcode 1 maps to WR.
- FSM states: IDLE, ACT, WAIT_RCD, CAS, WAIT_PRE, PRE, WAIT_RP.
  - IDLE: if q_count>0 and the tRP timer has expired, pop the head, latch its fields, go to ACT.
  - ACT: issue ACT; start the tRCD and tRAS counters.
  - WAIT_RCD: wait until T_RCD cycles after ACT, then go to CAS.
  - CAS: issue RD or WR; load the post-CAS counter with T_RTP (read) or T_WRP (write).
  - WAIT_PRE: wait until both the post-CAS counter and the tRAS counter expire.
  - PRE: issue PRE; load the T_RP counter.
  - WAIT_RP: wait for the T_RP counter to expire, then go to IDLE.
- Timing (closed page), with ACT issued in cycle c:
  - CAS in cycle c+T_RCD.
  - PRE in cycle max(CAS+T_RTP or CAS+T_WRP, c+T_RAS).
  - Next ACT no earlier than PRE+T_RP.
- Latency: a request accepted on edge E0 into an empty queue with the scheduler idle produces ACT with cmd_valid=1 in the cycle following edge E1.
- Timers are saturating down-counters, 8 bits wide; a value of 0 means expired.
- Requests are serviced strictly in order; no reordering.

Optional Feature:
OPEN_PAGE_EN
- Defined: open-page policy. After CAS the FSM returns to IDLE with the row left open; the open bg/bank/row are tracked (one row device-wide).
  - Next head request is a hit (same bg, bank, row): issue CAS directly, no earlier than T_CCD after the previous CAS.
  - Next head request is a miss: go to WAIT_PRE (respecting post-CAS and tRAS timers), then PRE, WAIT_RP, ACT.
  - Queue empty: the row stays open indefinitely.
- Undefined: closed-page policy exactly as described in Behaviour; the open-row tracking logic is not synthesized.

Test Plan:
- Single read, opn=0, addr=0x0_1234_5678, default params.
  - Required: ACT in cycle c with bg=addr[9:7], bank=addr[11:10], row=addr[33:18], col={addr[17:12],addr[5:2]}.
  - Required: RD at c+39, PRE at c+76, cmd_core matches the request.
- Single write, opn=1, followed by a second read.
  - Required: WR at c+39, PRE at c+133, second ACT at c+172.
- Push 16 requests with no service progress.
  - Required: q_count=16, req_ready=0, and a 17th request is not accepted.
  - Required: after the first pop, req_ready=1 and order is preserved.
- Illegal opcode opn=5.
  - Required: handshake completes, req_err pulses for 1 cycle, q_count is unchanged, no command issued.
- Assert rst during WAIT_RCD with 3 requests queued.
  - Required: all outputs return to reset values immediately, q_count=0, no RD or PRE afterwards.
- With OPEN_PAGE_EN, two reads to the same row, then a read to a different row.
  - Required: second RD 8 cycles after the first, no ACT between them.
  - Required: third request issues PRE, then ACT T_RP later.

Source files
------------

// File: rtl/ddr5_cmd_scheduler.sv
// ddr5_cmd_scheduler: 16-entry in-order request FIFO feeding a single-row DDR5
// command sequencer (ACT / RD / WR / PRE) with saturating 8-bit timing counters.
// Closed-page policy by default; define OPEN_PAGE_EN to keep the row open after
// CAS and serve same-row heads directly.
module ddr5_cmd_scheduler #(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int QUEUE_DEPTH    = 16,
    parameter int T_RCD          = 39,
    parameter int T_RAS          = 76,
    parameter int T_RTP          = 18,
    parameter int T_WRP          = 94,
    parameter int T_RP           = 39,
    parameter int T_CCD          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [CPU_CORE_WIDTH-1:0]      req_core,
    input  logic [MEM_OPN_WIDTH-1:0]       req_opn,
    input  logic [MEM_ADDR_WIDTH-1:0]      req_addr,
    output logic                           req_err,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_type,
    output logic [2:0]                     cmd_bg,
    output logic [1:0]                     cmd_bank,
    output logic [15:0]                    cmd_row,
    output logic [9:0]                     cmd_col,
    output logic [CPU_CORE_WIDTH-1:0]      cmd_core
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [MEM_OPN_WIDTH-1:0] OPN_WRITE = MEM_OPN_WIDTH'(1);
    localparam logic [MEM_OPN_WIDTH-1:0] OPN_FETCH = MEM_OPN_WIDTH'(2);

    // Each timer is loaded so that it reads 0 in the cycle where the FSM decides to
    // move to the gated command; the gated command then lands exactly T cycles after
    // its reference. tRP is checked one state later (from IDLE), hence one less.
    localparam logic [7:0] RCD_LD = 8'(T_RCD - 2);
    localparam logic [7:0] RAS_LD = 8'(T_RAS - 2);
    localparam logic [7:0] RTP_LD = 8'(T_RTP - 2);
    localparam logic [7:0] WRP_LD = 8'(T_WRP - 2);
    localparam logic [7:0] RP_LD  = 8'(T_RP - 3);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3, CMD_PRE = 3'd4
    } cmd_e;

    typedef struct packed {
        logic [CPU_CORE_WIDTH-1:0] core;
        logic                      wr;
        logic [2:0]                bg;
        logic [1:0]                bank;
        logic [15:0]               row;
        logic [9:0]                col;
    } entry_t;

    state_e                    state_q, state_d;
    entry_t                    mem_q [QUEUE_DEPTH];
    entry_t                    new_entry, head;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]            count_q;
    logic                      err_q, push, pop, handshake;
    logic [7:0]                rcd_q, ras_q, post_q, rp_q;
    logic [2:0]                cmd_bg_q;
    logic [1:0]                cmd_bank_q;
    logic [15:0]               cmd_row_q;
    logic [9:0]                cmd_col_q;
    logic [CPU_CORE_WIDTH-1:0] cmd_core_q;
    logic                      cur_wr_q;
    logic                      unused_addr_bits;

    function automatic logic [7:0] dec_sat(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    assign unused_addr_bits = ^{req_addr[MEM_ADDR_WIDTH-1:34], req_addr[6], req_addr[1:0]};

    assign req_ready = (count_q != FULL_CNT);
    assign handshake = req_valid && req_ready;
    assign push      = handshake && (req_opn <= OPN_FETCH);
    assign head      = mem_q[rd_ptr_q];
    assign new_entry = '{core: req_core, wr: (req_opn == OPN_WRITE), bg: req_addr[9:7],
                         bank: req_addr[11:10], row: req_addr[33:18],
                         col: {req_addr[17:12], req_addr[5:2]}};

`ifdef OPEN_PAGE_EN
    // The latched cmd_bg/bank/row always describe the open row while row_open_q is set.
    logic       row_open_q, head_hit;
    logic [7:0] ccd_q;
    localparam logic [7:0] CCD_LD = 8'(T_CCD - 2);
    assign head_hit = (head.bg == cmd_bg_q) && (head.bank == cmd_bank_q) && (head.row == cmd_row_q);

    // Open-row flag and CAS-to-CAS spacing counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_open_q <= 1'b0;
            ccd_q      <= 8'd0;
        end else begin
            ccd_q <= (state_q == S_CAS) ? CCD_LD : dec_sat(ccd_q);
            if (state_q == S_ACT)      row_open_q <= 1'b1;
            else if (state_q == S_PRE) row_open_q <= 1'b0;
        end
    end
`else
    logic [7:0] unused_ccd;
    assign unused_ccd = 8'(T_CCD);
`endif

    // Queue storage: written on push only.
    // NOTE: the entry array has no reset; occupancy is governed solely by the reset pointers/count, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    // Queue pointers, occupancy and the illegal-opcode pulse.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= handshake && !push;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state and head-pop decision.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
`ifdef OPEN_PAGE_EN
                    if (row_open_q) begin
                        if (!head_hit) begin
                            state_d = S_WAIT_PRE;
                        end else if (ccd_q == 8'd0) begin
                            pop     = 1'b1;
                            state_d = S_CAS;
                        end
                    end else if (rp_q == 8'd0) begin
                        pop     = 1'b1;
                        state_d = S_ACT;
                    end
`else
                    if (rp_q == 8'd0) begin
                        pop     = 1'b1;
                        state_d = S_ACT;
                    end
`endif
                end
            end
            S_ACT:      state_d = S_WAIT_RCD;
            S_WAIT_RCD: if (rcd_q == 8'd0) state_d = S_CAS;
`ifdef OPEN_PAGE_EN
            S_CAS:      state_d = S_IDLE;
`else
            S_CAS:      state_d = S_WAIT_PRE;
`endif
            S_WAIT_PRE: if (ras_q == 8'd0 && post_q == 8'd0) state_d = S_PRE;
            S_PRE:      state_d = S_WAIT_RP;
            S_WAIT_RP:  if (rp_q == 8'd0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs: one command per command state, NOP elsewhere.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_type  = CMD_NOP;
        case (state_q)
            S_ACT: begin cmd_valid = 1'b1; cmd_type = CMD_ACT; end
            S_CAS: begin cmd_valid = 1'b1; cmd_type = cur_wr_q ? CMD_WR : CMD_RD; end
            S_PRE: begin cmd_valid = 1'b1; cmd_type = CMD_PRE; end
            default: ;
        endcase
    end

    // Timing counters: loaded in the issuing command's cycle, otherwise count down to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_q  <= 8'd0;
            ras_q  <= 8'd0;
            post_q <= 8'd0;
            rp_q   <= 8'd0;
        end else begin
            rcd_q  <= (state_q == S_ACT) ? RCD_LD : dec_sat(rcd_q);
            ras_q  <= (state_q == S_ACT) ? RAS_LD : dec_sat(ras_q);
            post_q <= (state_q == S_CAS) ? (cur_wr_q ? WRP_LD : RTP_LD) : dec_sat(post_q);
            rp_q   <= (state_q == S_PRE) ? RP_LD : dec_sat(rp_q);
        end
    end

    // Serviced-request fields, latched when the head is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_bg_q   <= '0;
            cmd_bank_q <= '0;
            cmd_row_q  <= '0;
            cmd_col_q  <= '0;
            cmd_core_q <= '0;
            cur_wr_q   <= 1'b0;
        end else if (pop) begin
            cmd_bg_q   <= head.bg;
            cmd_bank_q <= head.bank;
            cmd_row_q  <= head.row;
            cmd_col_q  <= head.col;
            cmd_core_q <= head.core;
            cur_wr_q   <= head.wr;
        end
    end

    assign req_err  = err_q;
    assign q_count  = count_q;
    assign cmd_bg   = cmd_bg_q;
    assign cmd_bank = cmd_bank_q;
    assign cmd_row  = cmd_row_q;
    assign cmd_col  = cmd_col_q;
    assign cmd_core = cmd_core_q;

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Self-checking bench for ddr5_cmd_scheduler: directed cases plus random bursts,
// compared against a timestamp-level model of the command schedule.
module tb_ddr5_cmd_scheduler;
    localparam int T_RCD = 39, T_RAS = 76, T_RTP = 18, T_WRP = 94, T_RP = 39, T_CCD = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_err;
    logic [3:0]  req_core = '0;
    logic [2:0]  req_opn = '0;
    logic [63:0] req_addr = '0;
    logic [4:0]  q_count;
    logic        cmd_valid;
    logic [2:0]  cmd_type, cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  cmd_core;

    ddr5_cmd_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_core(req_core), .req_opn(req_opn), .req_addr(req_addr), .req_err(req_err),
        .q_count(q_count), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bg(cmd_bg),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_core(cmd_core)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int typ; logic [30:0] loc; logic [3:0] core; } cmd_t;
    cmd_t exp_q[$], got_q[$];

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: record every issued command; NOP cycles must report type 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) got_q.push_back('{cyc, int'(cmd_type), {cmd_bg, cmd_bank, cmd_row, cmd_col}, cmd_core});
            else check("nop_type", 64'(cmd_type), 64'd0);
        end
    end

    // Reference model: command cycles derived from the timing rules.
    int m_prev_pre, m_last_act, m_last_cas, m_last_post, m_last_cyc;
    bit m_open;
    logic [30:0] m_open_loc;
    logic [3:0]  m_open_core;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_prev_pre = -1000; m_last_act = -1000; m_last_cas = -1000; m_last_post = 0;
        m_open = 0; m_open_loc = '0; m_open_core = '0; m_last_cyc = cyc;
        exp_q.delete();
    endfunction

    function automatic void emit(input int c, input int t, input logic [30:0] loc, input logic [3:0] core);
        exp_q.push_back('{c, t, loc, core});
        m_last_cyc = imax(m_last_cyc, c);
    endfunction

    // a = index of the clock edge on which the request was accepted.
    function automatic void model_accept(input int a, input logic [3:0] core, input logic [2:0] opn, input logic [63:0] addr);
        logic [30:0] loc;
        int act, cas, pre, post, typ;
        loc  = {addr[9:7], addr[11:10], addr[33:18], addr[17:12], addr[5:2]};
        post = (opn == 3'd1) ? T_WRP : T_RTP;
        typ  = (opn == 3'd1) ? 3 : 2;
`ifdef OPEN_PAGE_EN
        if (m_open && m_open_loc[30:10] == loc[30:10]) begin
            cas = imax(a + 1, m_last_cas + T_CCD);
            emit(cas, typ, loc, core);
        end else begin
            if (m_open) begin
                pre = imax(imax(a, m_last_cas + 1) + 2, imax(m_last_cas + m_last_post, m_last_act + T_RAS));
                emit(pre, 4, m_open_loc, m_open_core);
                m_prev_pre = pre;
            end
            act = imax(a + 1, m_prev_pre + T_RP);
            cas = act + T_RCD;
            emit(act, 1, loc, core);
            emit(cas, typ, loc, core);
            m_last_act = act;
            m_open = 1;
        end
        m_last_cas = cas; m_last_post = post; m_open_loc = loc; m_open_core = core;
`else
        act = imax(a + 1, m_prev_pre + T_RP);
        cas = act + T_RCD;
        pre = imax(cas + post, act + T_RAS);
        emit(act, 1, loc, core);
        emit(cas, typ, loc, core);
        emit(pre, 4, loc, core);
        m_prev_pre = pre;
`endif
    endfunction

    // Drive one request starting at a negedge; wait (bounded) until it is accepted.
    task automatic push(input logic [3:0] core, input logic [2:0] opn, input logic [63:0] addr);
        bit ok = 0;
        req_valid = 1'b1; req_core = core; req_opn = opn; req_addr = addr;
        for (int n = 0; n < 4000 && !ok; n++) begin
            if (req_ready) begin
                ok = 1;
                if (opn <= 3'd2) model_accept(cyc + 1, core, opn, addr);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic drain(input string tag);
        cmd_t g, e;
        while (cyc < m_last_cyc + 20) @(negedge clk);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_cyc"},  64'(g.cyc),  64'(e.cyc));
            check({tag, "_type"}, 64'(g.typ),  64'(e.typ));
            check({tag, "_loc"},  64'(g.loc),  64'(e.loc));
            check({tag, "_core"}, 64'(g.core), 64'(e.core));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        cmd_t        first;
        int          c0;

        // Reset values while rst is held.
        #12;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_err",   64'(req_err),   64'd0);
        check("rst_count", 64'(q_count),   64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_type",  64'(cmd_type),  64'd0);
        check("rst_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core}, 64'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();

        // Reset asserted in WAIT_RCD with three requests queued.
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(4'(i + 1), 3'd0, 64'h1000 * (i + 1));
        while (cyc < c0 + 10) @(negedge clk);
        check("rcd_qcount", 64'(q_count), 64'd3);
        check("rcd_act_seen", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            first = got_q.pop_front();
            check("rcd_act_cyc", 64'(first.cyc), 64'(c0 + 2));
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 64'(q_count),   64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(cmd_valid), 64'd0);
        check("mid_rst_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core}, 64'd0);
        @(negedge clk); rst = 1'b0;
        got_q.delete();
        model_reset();
        repeat (200) @(negedge clk);
        check("post_rst_cmds", 64'(got_q.size()), 64'd0);
        check("post_rst_count", 64'(q_count), 64'd0);

        // Single read.
        push(4'd5, 3'd0, 64'h0_1234_5678);
        drain("rd1");

        // Write followed by a read.
        push(4'd2, 3'd1, 64'h3_8765_4320);
        push(4'd9, 3'd2, 64'h0_0ABC_DEF0);
        drain("wr_rd");

        // Two reads to one row, then a different row.
        push(4'd1, 3'd0, 64'h1_2340_0A84);
        push(4'd3, 3'd0, 64'h1_2343_F0B8);
        push(4'd4, 3'd0, 64'h2_0000_0A84);
        drain("page");

        // Illegal opcode: accepted, dropped, one-cycle error pulse.
        push(4'd7, 3'd5, 64'h0_5555_AAAA);
        check("ill_err_hi", 64'(req_err), 64'd1);
        check("ill_count",  64'(q_count), 64'd0);
        @(negedge clk);
        check("ill_err_lo", 64'(req_err), 64'd0);
        repeat (100) @(negedge clk);
        drain("ill");

        // Fill the queue: the first request is popped, sixteen more fill it.
        for (int i = 0; i < 17; i++) push(4'(i), 3'($urandom_range(2, 0)), {$urandom, $urandom});
        check("full_count", 64'(q_count),   64'd16);
        check("full_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1; req_core = 4'hF; req_opn = 3'd0; req_addr = 64'h0_0F0F_0F0C;
        @(negedge clk);
        check("full_hold", 64'(q_count), 64'd16);
        push(4'hF, 3'd0, 64'h0_0F0F_0F0C);
        drain("full");

        // Random bursts; half the follow-on requests reuse the previous row.
        addr = {$urandom, $urandom};
        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(5, 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1) addr = addr ^ ({32'h0, $urandom} & 64'h3F03C);
                else addr = {$urandom, $urandom};
                push(4'($urandom), 3'($urandom_range(2, 0)), addr);
                if ($urandom_range(3, 0) == 0) repeat ($urandom_range(150, 1)) @(negedge clk);
            end
            drain("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
